// File: rtl/bsg_realram_ctrl.sv
// bsg_realram_ctrl
//   Request-side controller sitting directly in front of the single-port
//   realram wrapper (port 0, RW). It accepts valid/ready read and write
//   requests, drives the wrapper's active-low chip/write enables, and
//   captures the returning read data into a 2-entry output FIFO that is
//   drained with a valid/yumi handshake. The wrapper returns read data
//   bit-complemented, so it is re-inverted on capture and data_o is true data.
//
//   Optional feature: define BSG_REALRAM_CTRL_INIT_EN to add an INIT state
//   that zero-fills the whole array (one address per cycle) after reset,
//   before the first request is accepted.
//
// Ports
//   clk          clock shared with the RAM wrapper
//   reset_n      asynchronous active-low reset
//   v_i/ready_o  request handshake; w_i selects write (1) or read (0)
//   addr_i       request address
//   data_i       write data
//   mask_i       write mask, 1 = bit written
//   v_o/yumi_i   read-data handshake; data_o is the FIFO head
//   ram_*_o      wrapper address, active-low ce/we, write data, write mask
//   ram_rd_i     wrapper read data (complemented), valid the cycle after the read
module bsg_realram_ctrl #(
  parameter int BITS       = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  v_i,
  input  logic                  w_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BITS-1:0]       data_i,
  input  logic [BITS-1:0]       mask_i,
  output logic                  ready_o,
  output logic                  v_o,
  output logic [BITS-1:0]       data_o,
  input  logic                  yumi_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_ce_n_o,
  output logic                  ram_we_n_o,
  output logic [BITS-1:0]       ram_wd_o,
  output logic [BITS-1:0]       ram_wmsk_o,
  input  logic [BITS-1:0]       ram_rd_i
);

  localparam logic [0:0] StIdle = 1'b1;
`ifdef BSG_REALRAM_CTRL_INIT_EN
  localparam logic [0:0] StInit = 1'b0;
`endif

  logic [0:0]      state_q, state_d;
  logic [1:0]      count_q;
  logic            rdPtr_q;
  logic            wrPtr_q;
  logic            rdPend_q;
  logic [BITS-1:0] mem_q [2];

  logic            accept;
  logic            enq;
  logic            deq;
  logic [2:0]      occ;

`ifdef BSG_REALRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] initAddr_q;
`endif

  // Credit accounting: every accepted read must have a FIFO slot reserved
  // for it, counting the one still in flight inside the RAM. A same-cycle
  // dequeue frees a slot early, which is what lets reads stream at full rate.
  // reset_n gates the handshake so nothing is accepted while reset is held.
  assign deq     = v_o & yumi_i;
  assign enq     = rdPend_q;
  assign occ     = {1'b0, count_q} + {2'b00, rdPend_q} - {2'b00, deq};
  assign ready_o = reset_n & (state_q == StIdle) & (occ < 3'd2);
  assign accept  = v_i & ready_o;
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rdPtr_q];

  // RAM drive is combinational so the wrapper samples the request at the
  // same edge that accepts it. Idle values are forced while reset is low so
  // the RAM goes quiet immediately, even mid-operation.
  always_comb begin
    ram_ce_n_o = 1'b1;
    ram_we_n_o = 1'b1;
    ram_addr_o = '0;
    ram_wd_o   = '0;
    ram_wmsk_o = '0;
    if (reset_n) begin
`ifdef BSG_REALRAM_CTRL_INIT_EN
      if (state_q == StInit) begin
        ram_ce_n_o = 1'b0;
        ram_we_n_o = 1'b0;
        ram_addr_o = initAddr_q;
        ram_wmsk_o = '1;
      end else
`endif
      if (accept) begin
        ram_ce_n_o = 1'b0;
        ram_addr_o = addr_i;
        if (w_i) begin
          ram_we_n_o = 1'b0;
          ram_wd_o   = data_i;
          ram_wmsk_o = mask_i;
        end
      end
    end
  end

  // Next-state logic: INIT falls through to IDLE once the last address has
  // been written; IDLE is terminal.
  always_comb begin
    state_d = state_q;
`ifdef BSG_REALRAM_CTRL_INIT_EN
    if ((state_q == StInit) && (&initAddr_q)) begin
      state_d = StIdle;
    end
`endif
  end

  // State register and the optional init sweep counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef BSG_REALRAM_CTRL_INIT_EN
      state_q    <= StInit;
      initAddr_q <= '0;
`else
      state_q    <= StIdle;
`endif
    end else begin
      state_q <= state_d;
`ifdef BSG_REALRAM_CTRL_INIT_EN
      if (state_q == StInit) begin
        initAddr_q <= initAddr_q + 1'b1;
      end
`endif
    end
  end

  // Read-return pipeline and output FIFO. ram_rd_i is only meaningful the
  // cycle after a read was accepted, so rdPend_q qualifies the enqueue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPend_q <= 1'b0;
      count_q  <= 2'd0;
      rdPtr_q  <= 1'b0;
      wrPtr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rdPend_q <= accept & ~w_i;
      if (enq) begin
        mem_q[wrPtr_q] <= ~ram_rd_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (deq) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Consumers must not take data that is not there.
  yumiOnlyWhenValid: assert property (@(posedge clk) disable iff (!reset_n) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_realram_ctrl.sv
// tb_bsg_realram_ctrl
//   Self-checking bench for bsg_realram_ctrl. A behavioural RAM model stands
//   in for the wrapper (complemented read data, one-cycle read latency). The
//   reference model is a plain array updated on every accepted write; every
//   accepted read pushes its expected data into a queue, and an independent
//   monitor pops and compares whenever the bench takes data via yumi_i.
//   Build with +define+BSG_REALRAM_CTRL_INIT_EN to exercise the init sweep.
module tb_bsg_realram_ctrl;

  logic       clk;
  logic       reset_n;
  logic       v_i;
  logic       w_i;
  logic [9:0] addr_i;
  logic [7:0] data_i;
  logic [7:0] mask_i;
  logic       ready_o;
  logic       v_o;
  logic [7:0] data_o;
  logic       yumi_i;
  logic [9:0] ram_addr_o;
  logic       ram_ce_n_o;
  logic       ram_we_n_o;
  logic [7:0] ram_wd_o;
  logic [7:0] ram_wmsk_o;
  logic [7:0] ram_rd_i;

  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  int         yumiMode = 0;
  logic       clearRam;

  logic [7:0] refMem [1024];
  logic [7:0] expQ [$];
  int         popCycles [$];

  logic [7:0] ramMem [1024];
  logic [7:0] ramRd;

  bsg_realram_ctrl #(.BITS(8), .ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .v_i        (v_i),
    .w_i        (w_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .mask_i     (mask_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .ram_addr_o (ram_addr_o),
    .ram_ce_n_o (ram_ce_n_o),
    .ram_we_n_o (ram_we_n_o),
    .ram_wd_o   (ram_wd_o),
    .ram_wmsk_o (ram_wmsk_o),
    .ram_rd_i   (ram_rd_i)
  );

  // Free-running clock and a cycle counter used for latency/streaming checks.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper model: masked writes, reads return complemented data next cycle.
  always @(posedge clk) begin
    if (clearRam) begin
      for (int i = 0; i < 1024; i++) ramMem[i] <= 8'h00;
      ramRd <= 8'h00;
    end else if (!ram_ce_n_o) begin
      if (!ram_we_n_o)
        ramMem[ram_addr_o] <= (ramMem[ram_addr_o] & ~ram_wmsk_o) | (ram_wd_o & ram_wmsk_o);
      else
        ramRd <= ~ramMem[ram_addr_o];
    end
  end
  assign ram_rd_i = ramRd;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: decides yumi_i from the current mode and, whenever data is
  // taken, compares it against the oldest outstanding expected read.
  initial begin
    bit take;
    logic [7:0] exp;
    yumi_i = 1'b0;
    forever begin
      @(negedge clk);
      take = 1'b0;
      if (v_o === 1'b1) begin
        if (yumiMode == 1) take = 1'b1;
        else if (yumiMode == 2) take = ($urandom_range(0, 1) == 1);
      end
      yumi_i = take;
      if (take) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", {31'd0, v_o}, 32'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("read_data", {24'd0, data_o}, {24'd0, exp});
          popCycles.push_back(cyc);
        end
      end
    end
  end

  // Present one request for one cycle; update the reference model on accept.
  task automatic applyStimulus(input bit w, input logic [9:0] a, input logic [7:0] d,
                               input logic [7:0] m, output bit acc);
    @(negedge clk);
    v_i = 1'b1; w_i = w; addr_i = a; data_i = d; mask_i = m;
    #1;
    acc = ready_o;
    if (acc) begin
      if (w) refMem[a] = (refMem[a] & ~m) | (d & m);
      else   expQ.push_back(refMem[a]);
    end
  endtask

  task automatic applyIdle();
    @(negedge clk);
    v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0;
  endtask

  // Hold a request until accepted, with a cycle budget.
  task automatic issue(input bit w, input logic [9:0] a, input logic [7:0] d, input logic [7:0] m);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) applyStimulus(w, a, d, m, acc);
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    yumiMode = 1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      applyIdle();
      #1;
      done = (expQ.size() == 0) && (v_o == 1'b0);
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int stalls;
    int errs;
    int k;
    logic [7:0] d;

    for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
    clearRam = 1'b1;
    reset_n = 1'b0;
    v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("reset_v_o", {31'd0, v_o}, 32'd0);
    checkOutput("reset_data_o", {24'd0, data_o}, 32'd0);
    checkOutput("reset_ce_n", {31'd0, ram_ce_n_o}, 32'd1);
    checkOutput("reset_we_n", {31'd0, ram_we_n_o}, 32'd1);
    checkOutput("reset_addr", {22'd0, ram_addr_o}, 32'd0);
    checkOutput("reset_wmsk", {24'd0, ram_wmsk_o}, 32'd0);
    clearRam = 1'b0;

    @(negedge clk);
    reset_n = 1'b1;
    #1;
`ifdef BSG_REALRAM_CTRL_INIT_EN
    // Init sweep: addresses 0..1023 written, ready_o held low until done.
    k = 0;
    errs = 0;
    while (ready_o !== 1'b1 && k < 1100) begin
      if (ram_addr_o !== k[9:0] || ram_we_n_o !== 1'b0 || ram_ce_n_o !== 1'b0 ||
          ram_wmsk_o !== 8'hFF || ram_wd_o !== 8'h00) errs++;
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("init_sweep_drive", errs, 0);
    checkOutput("init_first_ready_cycle", k, 1024);
`else
    checkOutput("first_cycle_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("idle_ce_n", {31'd0, ram_ce_n_o}, 32'd1);
    checkOutput("idle_v_o", {31'd0, v_o}, 32'd0);
`endif

    // Write then read 0x155, with exact 2-cycle read latency.
    yumiMode = 1;
    issue(1'b1, 10'h155, 8'hA5, 8'hFF);
    checkOutput("write_we_n", {31'd0, ram_we_n_o}, 32'd0);
    checkOutput("write_wd", {24'd0, ram_wd_o}, 32'hA5);
    checkOutput("write_wmsk", {24'd0, ram_wmsk_o}, 32'hFF);
    issue(1'b0, 10'h155, 8'h00, 8'h00);
    checkOutput("read_ce_n", {31'd0, ram_ce_n_o}, 32'd0);
    checkOutput("read_we_n", {31'd0, ram_we_n_o}, 32'd1);
    checkOutput("read_addr", {22'd0, ram_addr_o}, 32'h155);
    applyIdle();
    #1;
    checkOutput("read_v_o_t1", {31'd0, v_o}, 32'd0);
    applyIdle();
    #1;
    checkOutput("read_v_o_t2", {31'd0, v_o}, 32'd1);
    checkOutput("read_data_0x155", {24'd0, data_o}, 32'hA5);
    drain();

    // Masked write: only the low nibble cleared.
    issue(1'b1, 10'd3, 8'hFF, 8'hFF);
    issue(1'b1, 10'd3, 8'h00, 8'h0F);
    issue(1'b0, 10'd3, 8'h00, 8'h00);
    applyIdle();
    applyIdle();
    #1;
    checkOutput("masked_data", {24'd0, data_o}, 32'hF0);
    drain();

    // Backpressure: two reads fill the credits, a yumi frees one same-cycle.
    issue(1'b1, 10'd10, 8'h11, 8'hFF);
    issue(1'b1, 10'd11, 8'h22, 8'hFF);
    issue(1'b1, 10'd12, 8'h33, 8'hFF);
    applyIdle();
    yumiMode = 0;
    applyStimulus(1'b0, 10'd10, 8'h00, 8'h00, acc);
    checkOutput("bp_accept1", {31'd0, acc}, 32'd1);
    applyStimulus(1'b0, 10'd11, 8'h00, 8'h00, acc);
    checkOutput("bp_accept2", {31'd0, acc}, 32'd1);
    applyStimulus(1'b0, 10'd12, 8'h00, 8'h00, acc);
    checkOutput("bp_ready_drop", {31'd0, acc}, 32'd0);
    applyStimulus(1'b0, 10'd12, 8'h00, 8'h00, acc);
    checkOutput("bp_full_hold", {31'd0, acc}, 32'd0);
    yumiMode = 1;
    applyStimulus(1'b0, 10'd12, 8'h00, 8'h00, acc);
    yumiMode = 0;
    checkOutput("bp_yumi_reenable", {31'd0, acc}, 32'd1);
    applyIdle();
    drain();

    // Streaming: 16 reads back to back, results on 16 consecutive cycles.
    for (int i = 0; i < 16; i++) issue(1'b1, 10'(32 + i), 8'($urandom), 8'hFF);
    drain();
    popCycles.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 10'(32 + i), 8'h00, 8'h00, acc);
      if (!acc) begin
        stalls++;
        issue(1'b0, 10'(32 + i), 8'h00, 8'h00);
      end
    end
    drain();
    checkOutput("stream_stalls", stalls, 0);
    checkOutput("stream_count", popCycles.size(), 16);
    if (popCycles.size() == 16)
      checkOutput("stream_span", popCycles[15] - popCycles[0], 15);

    // Reset one cycle after a read accept: RAM idle and FIFO empty at once.
    issue(1'b0, 10'd40, 8'h00, 8'h00);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_v_o", {31'd0, v_o}, 32'd0);
    checkOutput("midreset_ce_n", {31'd0, ram_ce_n_o}, 32'd1);
    checkOutput("midreset_ready", {31'd0, ready_o}, 32'd0);
    expQ.delete();
    applyIdle();
    applyIdle();
    reset_n = 1'b1;
`ifdef BSG_REALRAM_CTRL_INIT_EN
    for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
`endif
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      applyIdle();
      #1;
      if (v_o !== 1'b0) errs++;
    end
    checkOutput("midreset_no_stale", errs, 0);
`ifdef BSG_REALRAM_CTRL_INIT_EN
    k = 0;
    while (ready_o !== 1'b1 && k < 1100) begin
      applyIdle();
      #1;
      k++;
    end
`endif

    // Randomized mix against the reference model.
    yumiMode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyIdle();
      end else begin
        d = 8'($urandom);
        issue($urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)), d, 8'($urandom));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bsg_realram_ctrl.md
Name: bsg_realram_ctrl

Overview:
- Request-side controller placed directly upstream of the 8x1024 single-port realram wrapper (port 0, RW).
- Accepts valid/ready read and write requests and drives the wrapper's active-low chip-enable and write-enable, address, write data and write mask.
- Captures returning read data into a 2-entry output buffer with a valid/yumi handshake.
- The wrapper returns read data bit-complemented; this block re-inverts it so `data_o` is true data.

Parameters:
- `BITS`, 8, data and mask width
- `ADDR_WIDTH`, 10, address width; array depth is 2^`ADDR_WIDTH`

Ports:
- `clk`  input  1  single clock, shared with the RAM wrapper
- `reset_n`  input  1  asynchronous active-low reset
- `v_i`  input  1  request valid
- `w_i`  input  1  1 = write, 0 = read
- `addr_i`  input  `ADDR_WIDTH`  request address
- `data_i`  input  `BITS`  write data
- `mask_i`  input  `BITS`  write mask, 1 = bit written
- `ready_o`  output  1  request accepted when `v_i` & `ready_o`
- `v_o`  output  1  read data valid
- `data_o`  output  `BITS`  read data (true polarity)
- `yumi_i`  input  1  consumer takes `data_o`; legal only when `v_o`=1
- `ram_addr_o`  output  `ADDR_WIDTH`  to wrapper `addri`
- `ram_ce_n_o`  output  1  to wrapper `cei`, active-low
- `ram_we_n_o`  output  1  to wrapper `wei`, active-low
- `ram_wd_o`  output  `BITS`  to wrapper `wdi`
- `ram_wmsk_o`  output  `BITS`  to wrapper `wmski`
- `ram_rd_i`  input  `BITS`  from wrapper `rd_out`, complemented data

Behaviour:
- Reset (`reset_n`=0, async), all state cleared:
  - `ready_o`=0, `v_o`=0, `data_o`=0
  - `ram_ce_n_o`=1, `ram_we_n_o`=1, `ram_addr_o`=0, `ram_wd_o`=0, `ram_wmsk_o`=0
  - FIFO count=0, `rd_pend`=0, FSM state=INIT if the optional feature is compiled in, else IDLE
- FSM states:
  - INIT (optional feature only)
  - IDLE: normal operation; terminal state
- RAM drive in IDLE is combinational from the request:
  - On accept: `ram_ce_n_o`=0, `ram_addr_o`=`addr_i`.
  - Write: `ram_we_n_o`=0, `ram_wd_o`=`data_i`, `ram_wmsk_o`=`mask_i`.
  - Read: `ram_we_n_o`=1, `ram_wmsk_o`=0.
  - No accept: `ram_ce_n_o`=1, `ram_we_n_o`=1.
- Read timing:
  - Read accepted in cycle T; RAM samples at the T→T+1 edge.
  - `ram_rd_i` is valid during T+1 and is written to the FIFO as ~`ram_rd_i` at the T+1→T+2 edge.
  - `v_o`=1 from T+2. Accept-to-`v_o` latency is 2 cycles.
- Write timing: produces no response; complete at the edge after accept.
- `rd_pend` (1 bit) = a read was accepted last cycle.
- Credit rule:
  - occ = FIFO count + `rd_pend` − (`v_o` & `yumi_i`)
  - `ready_o` = (state==IDLE) & (occ < 2); the rule applies to writes and reads alike.
  - `ready_o` depends combinationally on `yumi_i`.
  - Guarantees the FIFO never overflows; full throughput of one read per cycle with continuous `yumi_i`.
- Output FIFO:
  - 2 entries, FIFO order; `data_o` = head entry; `v_o` = count≠0.
  - Simultaneous enqueue and dequeue: count unchanged, order preserved.
- Full: count=2 and no yumi → `ready_o`=0.
- Empty: `v_o`=0; `data_o` holds its last value, no checking required.
- Reset mid-read: pending data is discarded, FIFO is emptied, and the RAM is idle immediately.
- `yumi_i` while `v_o`=0 is illegal; assert it in simulation.
- Address wrap is not applicable; addresses are used as given.

Optional Feature:
- Macro: `BSG_REALRAM_CTRL_INIT_EN`.
- Defined:
  - After reset the FSM is in INIT. An internal counter sweeps addresses 0..2^`ADDR_WIDTH`−1, one per cycle.
  - Each cycle drives `ram_ce_n_o`=0, `ram_we_n_o`=0, `ram_wd_o`=0, `ram_wmsk_o`=all ones.
  - `ready_o`=0 throughout INIT. After the last address the FSM moves to IDLE.
  - The first `ready_o`=1 occurs 2^`ADDR_WIDTH` cycles after reset release; 1024 with defaults.
  - Reset during INIT restarts the sweep at address 0.
- Undefined: no INIT state and no counter; IDLE with `ready_o`=1 in the first cycle after reset release.

Test Plan:
- Reset then idle:
  - Without macro: `ready_o`=1 on cycle 1, `ram_ce_n_o`=1, `v_o`=0.
  - With macro: `ready_o`=0 for 1024 cycles; `ram_addr_o` counts 0→1023 with `ram_we_n_o`=0.
- Write then read:
  - Stimulus: write addr 0x155 data 0xA5 mask 0xFF; read 0x155 in cycle T.
  - Response: `ram_ce_n_o`=0, `ram_we_n_o`=1 in T; `v_o`=1 in T+2 with `data_o`=0xA5 (model returns 0x5A).
- Masked write:
  - Stimulus: write 0xFF mask 0xFF, then write 0x00 mask 0x0F to addr 3, then read addr 3.
  - Response: `data_o`=0xF0.
- Backpressure:
  - Stimulus: 3 back-to-back reads with `yumi_i`=0.
  - Response: `ready_o` drops after the 2nd accept. Raising `yumi_i` for one cycle re-enables `ready_o` in that same cycle. Data returns in order.
- Streaming: 16 consecutive reads with `yumi_i`=1 whenever `v_o`=1 → `ready_o` stays 1 and 16 results arrive on 16 consecutive cycles.
- Reset mid-operation: assert `reset_n`=0 one cycle after a read accept → `v_o`=0, `ram_ce_n_o`=1 immediately; no stale data after release.
